// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared state encodings and defaults for the switch debouncer
package sw_pkg;
  localparam logic [0:0]  ST_STABLE           = 1'b0;
  localparam logic [0:0]  ST_CHECK            = 1'b1;
  localparam int unsigned DEF_NB_SW           = 4;
  localparam int unsigned DEF_NB_COUNTER      = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - synchronizer, stability counter and edge strobes for one switch bit
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned NB_COUNTER      = DEF_NB_COUNTER,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall,
  output logic o_strobe_next
);

  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);

  logic                  sync1_q, sync2_q;
  logic [0:0]            state_q, state_d;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic                  sw_q, sw_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != sw_q) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end
      end
      default: begin
        // A return to the accepted level at any point is a bounce: drop the count.
        if (sync2_q == sw_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          sw_d    = ~sw_q;
          rise_d  = ~sw_q;
          fall_d  = sw_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_sw          = sw_q;
  assign o_rise        = rise_q;
  assign o_fall        = fall_q;
  assign o_strobe_next = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch debouncer array with combined change strobe
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned NB_SW           = DEF_NB_SW,
  parameter int unsigned NB_COUNTER      = DEF_NB_COUNTER,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall,
  output logic             o_change
);

  logic [NB_SW-1:0] strobe_next;
  logic             change_q, change_d;

  for (genvar g = 0; g < NB_SW; g++) begin : g_bit
    sw_debounce_bit #(
      .NB_COUNTER     (NB_COUNTER),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_sw         (i_sw[g]),
      .o_sw         (o_sw[g]),
      .o_rise       (o_rise[g]),
      .o_fall       (o_fall[g]),
      .o_strobe_next(strobe_next[g])
    );
  end

  // Built from next-state strobes so it lands in the same cycle as o_rise/o_fall.
  assign change_d = |strobe_next;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      change_q <= 1'b0;
    end else begin
      change_q <= change_d;
    end
  end

  assign o_change = change_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - randomized and directed checks of sw_debounce against a run-length model
module tb_sw_debounce;

  logic       clock;
  logic       i_reset;
  logic [3:0] i_sw;
  logic [3:0] sw4, rise4, fall4;
  logic [3:0] sw1, rise1, fall1;
  logic       chg4, chg1;

  int   checks;
  int   errors;
  logic armed;

  sw_debounce #(.NB_SW(4), .NB_COUNTER(20), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw),
    .o_sw(sw4), .o_rise(rise4), .o_fall(fall4), .o_change(chg4)
  );

  sw_debounce #(.NB_SW(4), .NB_COUNTER(20), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clock(clock), .i_reset(i_reset), .i_sw(i_sw),
    .o_sw(sw1), .o_rise(rise1), .o_fall(fall1), .o_change(chg1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: pins pass two sample stages, then a level is accepted once the
  // synchronized value has disagreed with the output for D+1 consecutive samples.
  logic [3:0] m_s1 [2];
  logic [3:0] m_s2 [2];
  logic [3:0] m_o  [2];
  logic [3:0] m_r  [2];
  logic [3:0] m_f  [2];
  logic       m_c  [2];
  int         m_run[2][4];

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_s1[n] = '0; m_s2[n] = '0; m_o[n] = '0; m_r[n] = '0; m_f[n] = '0; m_c[n] = 1'b0;
      for (int b = 0; b < 4; b++) m_run[n][b] = 0;
    end
  end

  always @(posedge clock) begin
    int d;
    for (int n = 0; n < 2; n++) begin
      d = (n == 0) ? 4 : 1;
      if (i_reset) begin
        m_s1[n] = '0; m_s2[n] = '0; m_o[n] = '0; m_r[n] = '0; m_f[n] = '0; m_c[n] = 1'b0;
        for (int b = 0; b < 4; b++) m_run[n][b] = 0;
      end else begin
        m_r[n] = '0;
        m_f[n] = '0;
        for (int b = 0; b < 4; b++) begin
          if (m_s2[n][b] != m_o[n][b]) begin
            m_run[n][b] = m_run[n][b] + 1;
            if (m_run[n][b] == d + 1) begin
              if (m_o[n][b]) m_f[n][b] = 1'b1;
              else           m_r[n][b] = 1'b1;
              m_o[n][b]   = ~m_o[n][b];
              m_run[n][b] = 0;
            end
          end else begin
            m_run[n][b] = 0;
          end
        end
        m_c[n]  = |(m_r[n] | m_f[n]);
        m_s2[n] = m_s1[n];
        m_s1[n] = i_sw;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (armed) begin
      chk("sw_d4",   sw4,          m_o[0]);
      chk("rise_d4", rise4,        m_r[0]);
      chk("fall_d4", fall4,        m_f[0]);
      chk("chg_d4",  {3'b000, chg4}, {3'b000, m_c[0]});
      chk("sw_d1",   sw1,          m_o[1]);
      chk("rise_d1", rise1,        m_r[1]);
      chk("fall_d1", fall1,        m_f[1]);
      chk("chg_d1",  {3'b000, chg1}, {3'b000, m_c[1]});
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Literal checks are taken just after a falling edge, clear of the model process.
  task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
    #1;
    chk(name, act, exp);
  endtask

  task automatic clean_reset();
    i_reset = 1'b1;
    i_sw    = 4'b0000;
    cyc(2);
    i_reset = 1'b0;
    cyc(10);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    armed   = 1'b0;
    i_reset = 1'b1;
    i_sw    = 4'b1010;

    // Reset with switches held high: outputs stay 0, then one normal rise.
    cyc(1);
    armed = 1'b1;
    lit("rst_sw", sw4, 4'b0000);
    lit("rst_rise", rise4, 4'b0000);
    i_reset = 1'b0;
    cyc(6);
    lit("post_rst_sw_early", sw4, 4'b0000);
    cyc(1);
    lit("post_rst_sw", sw4, 4'b1010);
    lit("post_rst_rise", rise4, 4'b1010);
    cyc(1);
    lit("post_rst_rise_off", rise4, 4'b0000);

    // Clean rise and fall on bit 0.
    clean_reset();
    i_sw = 4'b0001;
    cyc(7);
    lit("clean_sw", sw4, 4'b0001);
    lit("clean_rise", rise4, 4'b0001);
    lit("clean_chg", {3'b000, chg4}, 4'b0001);
    cyc(1);
    lit("clean_rise_off", rise4, 4'b0000);
    lit("clean_chg_off", {3'b000, chg4}, 4'b0000);
    i_sw = 4'b0000;
    cyc(7);
    lit("clean_fall", fall4, 4'b0001);
    lit("clean_sw0", sw4, 4'b0000);

    // Bounce on bit 1 never accepted at D=4.
    clean_reset();
    i_sw = 4'b0010; cyc(1);
    i_sw = 4'b0000; cyc(1);
    i_sw = 4'b0010; cyc(2);
    i_sw = 4'b0000; cyc(12);
    lit("bounce_sw", sw4, 4'b0000);

    // Bounce then settle on bit 2.
    clean_reset();
    i_sw = 4'b0100; cyc(1);
    i_sw = 4'b0000; cyc(1);
    i_sw = 4'b0100;
    cyc(6);
    lit("settle_early", sw4, 4'b0000);
    cyc(1);
    lit("settle_rise", rise4, 4'b0100);

    // All bits together.
    clean_reset();
    i_sw = 4'b1111;
    cyc(7);
    lit("simul_rise", rise4, 4'b1111);
    lit("simul_chg", {3'b000, chg4}, 4'b0001);
    cyc(1);
    lit("simul_chg_off", {3'b000, chg4}, 4'b0000);

    // Reset in the middle of a pending rise on bit 3.
    clean_reset();
    i_sw = 4'b1000;
    cyc(4);
    i_reset = 1'b1;
    cyc(1);
    lit("midrst_sw", sw4, 4'b0000);
    i_reset = 1'b0;
    cyc(6);
    lit("midrst_early", sw4, 4'b0000);
    cyc(1);
    lit("midrst_rise", rise4, 4'b1000);

    // Random bouncing with occasional resets; the compare process does the checking.
    clean_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3, 0) == 0) i_sw[b] = ~i_sw[b];
      i_reset = ($urandom_range(199, 0) == 0);
      cyc(1);
    end
    i_reset = 1'b0;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-side conditioner for the LED/switch design: synchronizes the raw board switches to `clock`, debounces each bit independently, and delivers stable levels plus one-cycle edge strobes. It sits between the board pins and the `i_sw` input of the LED top level. It is the input-direction counterpart of the LED output path: the counter/shift-register chain drives pins out, and this block qualifies pins in. The edge strobes can drive a `valid`-style single-cycle input directly.

## Interface
- `NB_SW`, 4, number of switch bits conditioned.
- `NB_COUNTER`, 20, width of each per-bit stability counter.
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before a new level is accepted; legal range 1 … 2^NB_COUNTER.

- `clock` input 1, single clock for the whole block.
- `i_reset` input 1, reset; one clock; reset is synchronous and active-high.
- `i_sw` input NB_SW, raw asynchronous switch pins.
- `o_sw` output NB_SW, debounced switch level.
- `o_rise` output NB_SW, one-cycle strobe per bit on an accepted 0→1 transition.
- `o_fall` output NB_SW, one-cycle strobe per bit on an accepted 1→0 transition.
- `o_change` output 1, OR-reduction of `o_rise | o_fall`, registered in the same cycle as the strobes.

## Operation
- Two-flop synchronizer per bit (`sync1`, `sync2`), reset to 0. Only `sync2` feeds the FSM.
- Per-bit FSM with two states:
  - `STABLE`: if `sync2 != o_sw`, go to `CHECK` and set `cnt = 0`; otherwise stay.
  - `CHECK`, input returns (`sync2 == o_sw`): go to `STABLE`, set `cnt = 0`, no output change (bounce rejected).
  - `CHECK`, input still differs, `cnt == DEBOUNCE_CYCLES-1`: toggle `o_sw`, pulse `o_rise` or `o_fall` for exactly one cycle, set `cnt = 0`, go to `STABLE`.
  - `CHECK`, input still differs, otherwise: `cnt <= cnt + 1`.
- Counter arithmetic is unsigned and NB_COUNTER wide. It never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.
- Bits are fully independent. Any mix of bits may assert strobes in the same cycle, and `o_change` asserts once for that cycle.
- Strobes are registered outputs. `o_rise` and `o_fall` are mutually exclusive per bit.

## Timing
- Reset (sampled on a rising `clock` edge with `i_reset = 1`):
  - `sync1`, `sync2`, `o_sw`, `o_rise`, `o_fall`, `o_change` and every `cnt` are 0.
  - All FSMs are in `STABLE`.
- Reset mid-`CHECK` discards the pending transition. No strobe is emitted on, or after, the reset edge.
- Switch held at 1 through reset: after release, it is treated as a normal 0→1 transition and produces one `o_rise`.
- Latency:
  - `i_sw` new value first sampled at edge t0; it stays stable thereafter.
  - `sync2` shows it at t0+1; the FSM enters `CHECK` at t0+2.
  - `o_sw` updates and the strobe asserts at edge t0+2+DEBOUNCE_CYCLES.
  - The strobe deasserts at the following edge.
- A bounce of any length shorter than `DEBOUNCE_CYCLES` cycles (as seen at `sync2`) produces no output change and restarts the count.
- `DEBOUNCE_CYCLES = 1`: latency is 3 edges, and single-cycle glitches are still rejected.

## Structure
- Shared package/include `sw_pkg`:
  - state encodings `ST_STABLE = 1'b0`, `ST_CHECK = 1'b1`;
  - default `NB_SW`;
  - default `DEBOUNCE_CYCLES`.
- Sub-module `sw_debounce_bit`: synchronizer, counter, FSM and edge registers for a single bit, parameterized by `NB_COUNTER` and `DEBOUNCE_CYCLES`.
- `sw_debounce` instantiates `NB_SW` copies in a generate loop and registers `o_change`.

## Test plan
- Reset: `i_reset = 1` for 2 cycles with `i_sw = 4'b1010` → all outputs 0 during reset. After release, with `DEBOUNCE_CYCLES = 4`, `o_sw = 4'b1010` and `o_rise = 4'b1010` for exactly one cycle, 6 edges after the first sampling edge.
- Clean edge: `DEBOUNCE_CYCLES = 4`, `i_sw[0]` 0→1 at edge t0 → `o_sw[0] = 1`, `o_rise[0] = 1` and `o_change = 1` at t0+6; all three strobes deassert at t0+7. A later 1→0 gives `o_fall[0]` with the same latency.
- Bounce rejection: `DEBOUNCE_CYCLES = 4`, `i_sw[1]` pattern 1,0,1,1,0 then held 0 → no strobe on bit 1, `o_sw[1]` stays 0.
- Bounce then settle: `i_sw[2]` pattern 1,0 then held 1 from edge t1 → exactly one `o_rise[2]`, at t1+6.
- Simultaneous: `i_sw` 4'b0000→4'b1111 in one cycle → `o_rise = 4'b1111` in a single cycle, `o_change` high for one cycle only.
- Reset mid-check: `i_sw[3]` rises, then `i_reset` is pulsed at t0+4 → no strobe before reset. After reset, `o_rise[3]` appears 6 edges after the first post-reset sampling edge.
